// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared constants for the data memory controller: opcode and funct3
// encodings, FSM state encodings, byte-lane masks, and small decode
// helpers for legality, alignment and lane selection.
package data_mem_ctrl_pkg;

  localparam int OPCODE_WIDTH = 7;
  localparam int FUNCT3_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 7'b0100011;

  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_LHU = 3'b101;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Unshifted lane masks; shifted left by addr[1:0] to reach the target lanes.
  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Access size lives in funct3[1:0]: 00 byte, 01 halfword, 10 word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] opcode,
                                    input logic [FUNCT3_WIDTH-1:0] funct3);
    logic legal;
    legal = 1'b0;
    if (opcode == OPCODE_LOAD)
      legal = (funct3 == FUNCT3_LB)  || (funct3 == FUNCT3_LH) ||
              (funct3 == FUNCT3_LW)  || (funct3 == FUNCT3_LBU) ||
              (funct3 == FUNCT3_LHU);
    else if (opcode == OPCODE_STORE)
      legal = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) ||
              (funct3 == FUNCT3_SW);
    return legal;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_HALF)
      mis = addr_lo[0];
    else if (size == SIZE_WORD)
      mis = |addr_lo;
    return mis;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = LANE_MASK_BYTE;
      SIZE_HALF: mask = LANE_MASK_HALF;
      SIZE_WORD: mask = LANE_MASK_WORD;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// load_extend
// Selects the addressed byte/halfword from a little-endian read word and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports:
//   rdata   - raw read word from memory
//   addr_lo - byte offset within the word
//   funct3  - load size/sign
//   ext     - extended load result
module load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0]             rdata,
  input  logic [1:0]              addr_lo,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  output logic [31:0]             ext
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed lane(s) down to bit 0 before extending.
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      FUNCT3_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LBU: ext = {24'h000000, shifted[7:0]};
      FUNCT3_LHU: ext = {16'h0000, shifted[15:0]};
      FUNCT3_LW:  ext = rdata;
      default:    ext = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Sequences one load/store at a time between the memory stage and a
// word-wide data memory with a ready handshake. Flags illegal, misaligned
// and timed-out accesses; stalls the pipeline while busy.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake from the memory stage
//   opcode, funct3        - access type and size/sign
//   addr, wdata           - byte address, right-justified store data
//   stall                 - hold pipeline
//   resp_valid/data/err   - one-cycle completion pulse with result
//   mem_en/we/addr/wdata  - memory request (held until mem_ready)
//   mem_rdata, mem_ready  - memory read data and completion
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [N-1:0]            addr,
  input  logic [N-1:0]            wdata,
  output logic                    stall,
  output logic                    resp_valid,
  output logic [N-1:0]            resp_data,
  output logic                    resp_err,
  output logic                    mem_en,
  output logic [3:0]              mem_we,
  output logic [N-1:0]            mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic [N-1:0]            mem_rdata,
  input  logic                    mem_ready
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_load_q, is_load_d;
  logic [FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [N-1:0]            resp_data_q, resp_data_d;
  logic                    mem_en_q, mem_en_d;
  logic [3:0]              mem_we_q, mem_we_d;
  logic [N-1:0]            mem_addr_q, mem_addr_d;
  logic [N-1:0]            mem_wdata_q, mem_wdata_d;
  logic [N-1:0]            load_word;

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .ext     (load_word)
  );

  // rst_n gates stall so a reset mid-access releases the pipeline at once.
  assign req_ready = (state_q == ST_IDLE);
  assign stall     = req_valid & rst_n & (state_q != ST_RESP);

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state logic. Response outputs are computed for the cycle being
  // entered, so resp_valid is high exactly while the FSM sits in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;
    mem_en_d     = 1'b0;
    mem_we_d     = 4'b0000;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_load_d = (opcode == OPCODE_LOAD);
          funct3_d  = funct3;
          addr_lo_d = addr[1:0];
          if (!is_legal(opcode, funct3) || is_misaligned(funct3[1:0], addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d    = ST_ACCESS;
            cnt_d      = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = {addr[N-1:2], 2'b00};
            if (opcode == OPCODE_STORE) begin
              mem_we_d    = lane_mask(funct3[1:0]) << addr[1:0];
              mem_wdata_d = wdata << {addr[1:0], 3'b000};
            end else begin
              mem_wdata_d = '0;
            end
          end
        end
      end

      ST_ACCESS: begin
        // mem_ready takes priority over an expiring timeout.
        if (mem_ready) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          if (is_load_q)
            resp_data_d = load_word;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_CNT)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Directed testbench for data_mem_ctrl (TIMEOUT=4). Drives one request at
// a time, plays the memory side from the stimulus task, and compares
// latency, memory-side signals and responses against hand-computed values.
module tb_data_mem_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  // Observations captured by applyStimulus for the caller to check.
  int          obs_latency;
  int          obs_en_cycles;
  logic [31:0] obs_data;
  logic        obs_err;
  logic [31:0] obs_addr;
  logic [3:0]  obs_we;
  logic [31:0] obs_wdata;
  logic        obs_stall_bad;
  logic        obs_resp_stall;
  logic        obs_resp_ready;
  logic        obs_resp_en;

  data_mem_ctrl #(.N(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request and act as the memory: mem_ready is raised during
  // ACCESS cycle number wait_cycles+1 (never if wait_cycles < 0).
  // Latency is counted in clock cycles from the accept edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int wait_cycles, input logic [31:0] rd);
    int  cycles;
    bit  done;
    obs_latency    = 0;
    obs_en_cycles  = 0;
    obs_data       = 32'h0;
    obs_err        = 1'b0;
    obs_addr       = 32'h0;
    obs_we         = 4'h0;
    obs_wdata      = 32'h0;
    obs_stall_bad  = 1'b0;
    obs_resp_stall = 1'b1;
    obs_resp_ready = 1'b1;
    obs_resp_en    = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    opcode    = op;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mem_rdata = rd;
    mem_ready = 1'b0;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      mem_ready = 1'b0;
      if (resp_valid) begin
        done           = 1'b1;
        obs_latency    = cycles;
        obs_data       = resp_data;
        obs_err        = resp_err;
        obs_resp_stall = stall;
        obs_resp_ready = req_ready;
        obs_resp_en    = mem_en;
      end else begin
        if (stall !== 1'b1) obs_stall_bad = 1'b1;
        if (mem_en) begin
          obs_en_cycles++;
          obs_addr  = mem_addr;
          obs_we    = mem_we;
          obs_wdata = mem_wdata;
          if (wait_cycles >= 0 && obs_en_cycles == wait_cycles + 1)
            mem_ready = 1'b1;
        end
      end
    end
    if (!done) checkOutput("resp_bound", 32'd0, 32'd1);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'h0;
    funct3    = 3'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    opcode    = 7'h0;
    funct3    = 3'h0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;

    #12;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW, zero wait
    applyStimulus(OP_LOAD, F_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    checkOutput("lw_latency", obs_latency, 2);
    checkOutput("lw_en_cycles", obs_en_cycles, 1);
    checkOutput("lw_mem_addr", obs_addr, 32'h100);
    checkOutput("lw_mem_we", obs_we, 4'b0000);
    checkOutput("lw_data", obs_data, 32'hDEADBEEF);
    checkOutput("lw_err", obs_err, 0);
    checkOutput("lw_stall", obs_stall_bad, 0);
    checkOutput("lw_resp_stall", obs_resp_stall, 0);
    checkOutput("lw_resp_ready", obs_resp_ready, 0);
    checkOutput("lw_resp_en", obs_resp_en, 0);

    // Byte / halfword load extension
    applyStimulus(OP_LOAD, F_B, 32'h103, 32'h0, 0, 32'h80112233);
    checkOutput("lb_data", obs_data, 32'hFFFFFF80);
    checkOutput("lb_mem_addr", obs_addr, 32'h100);
    applyStimulus(OP_LOAD, F_BU, 32'h103, 32'h0, 0, 32'h80112233);
    checkOutput("lbu_data", obs_data, 32'h00000080);
    applyStimulus(OP_LOAD, F_H, 32'h102, 32'h0, 0, 32'h80112233);
    checkOutput("lh_data", obs_data, 32'hFFFF8011);
    applyStimulus(OP_LOAD, F_HU, 32'h102, 32'h0, 0, 32'h80112233);
    checkOutput("lhu_data", obs_data, 32'h00008011);
    applyStimulus(OP_LOAD, F_H, 32'h100, 32'h0, 0, 32'h80112233);
    checkOutput("lh_lo_data", obs_data, 32'h00002233);
    applyStimulus(OP_LOAD, F_B, 32'h101, 32'h0, 0, 32'h80112233);
    checkOutput("lb_lane1_data", obs_data, 32'h00000022);

    // SB with 3 wait cycles
    applyStimulus(OP_STORE, F_B, 32'h0001_0002, 32'h000000AB, 3, 32'h0);
    checkOutput("sb_latency", obs_latency, 5);
    checkOutput("sb_mem_addr", obs_addr, 32'h0001_0000);
    checkOutput("sb_mem_we", obs_we, 4'b0100);
    checkOutput("sb_mem_wdata", obs_wdata, 32'h00AB0000);
    checkOutput("sb_stall", obs_stall_bad, 0);
    checkOutput("sb_data", obs_data, 0);
    checkOutput("sb_err", obs_err, 0);

    // SH upper half and SW
    applyStimulus(OP_STORE, F_H, 32'h202, 32'h0000BEEF, 1, 32'h0);
    checkOutput("sh_latency", obs_latency, 3);
    checkOutput("sh_mem_we", obs_we, 4'b1100);
    checkOutput("sh_mem_wdata", obs_wdata, 32'hBEEF0000);
    applyStimulus(OP_STORE, F_W, 32'h200, 32'h12345678, 0, 32'h0);
    checkOutput("sw_mem_we", obs_we, 4'b1111);
    checkOutput("sw_mem_wdata", obs_wdata, 32'h12345678);
    checkOutput("sw_mem_addr", obs_addr, 32'h200);

    // Misaligned requests
    applyStimulus(OP_LOAD, F_W, 32'h102, 32'h0, 0, 32'h11111111);
    checkOutput("mis_lw_latency", obs_latency, 1);
    checkOutput("mis_lw_en", obs_en_cycles, 0);
    checkOutput("mis_lw_err", obs_err, 1);
    checkOutput("mis_lw_data", obs_data, 0);
    applyStimulus(OP_STORE, F_H, 32'h101, 32'h1234, 0, 32'h0);
    checkOutput("mis_sh_latency", obs_latency, 1);
    checkOutput("mis_sh_en", obs_en_cycles, 0);
    checkOutput("mis_sh_err", obs_err, 1);

    // Illegal requests
    applyStimulus(OP_ALU, F_W, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ill_op_err", obs_err, 1);
    checkOutput("ill_op_en", obs_en_cycles, 0);
    applyStimulus(OP_LOAD, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ill_ld_f3_err", obs_err, 1);
    applyStimulus(OP_STORE, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    checkOutput("ill_st_f3_err", obs_err, 1);
    checkOutput("ill_st_f3_lat", obs_latency, 1);

    // Timeout (TIMEOUT=4) with mem_ready never asserted
    applyStimulus(OP_LOAD, F_W, 32'h300, 32'h0, -1, 32'h55AA55AA);
    checkOutput("to_en_cycles", obs_en_cycles, 5);
    checkOutput("to_latency", obs_latency, 6);
    checkOutput("to_err", obs_err, 1);
    checkOutput("to_data", obs_data, 0);

    // mem_ready in the cycle the counter reaches TIMEOUT wins
    applyStimulus(OP_LOAD, F_W, 32'h300, 32'h0, 4, 32'h55AA55AA);
    checkOutput("to_edge_en", obs_en_cycles, 5);
    checkOutput("to_edge_lat", obs_latency, 6);
    checkOutput("to_edge_err", obs_err, 0);
    checkOutput("to_edge_data", obs_data, 32'h55AA55AA);

    // Reset asserted during ACCESS
    @(negedge clk);
    req_valid = 1'b1;
    opcode    = OP_LOAD;
    funct3    = F_W;
    addr      = 32'h400;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_pre_en", mem_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_en", mem_en, 0);
    checkOutput("mid_rst_stall", stall, 0);
    checkOutput("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;

    applyStimulus(OP_LOAD, F_W, 32'h404, 32'h0, 1, 32'hCAFEF00D);
    checkOutput("post_rst_lat", obs_latency, 3);
    checkOutput("post_rst_data", obs_data, 32'hCAFEF00D);
    checkOutput("post_rst_err", obs_err, 0);
    checkOutput("post_rst_addr", obs_addr, 32'h404);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
